// File: rtl/ssd_scan_driver.sv
// Scans a 20-bit symbol word onto a 4-digit common-anode 7-seg display, latched once per frame.
// Outputs lag tick/idx by 1 cycle; no backpressure. Optional per-digit blink under `SSD_BLINK_EN.
module ssd_scan_driver #(
    parameter int DIGIT_TICKS = 100000,
    parameter int BLINK_TICKS = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] sym,
    input  logic [3:0]  blink_mask,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_start
);

    localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;

    logic [TW-1:0] r_tick;
    logic [1:0]    r_idx;
    logic [19:0]   r_shadow;
    logic          r_loaded;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;
    logic          r_frame_start;

    logic          w_wrap;
    logic          w_frame_end;
    logic          w_blank;
    logic [4:0]    w_code;
    logic [6:0]    w_glyph;

    assign w_wrap      = (r_tick == TW'(DIGIT_TICKS - 1));
    assign w_frame_end = w_wrap && (r_idx == 2'd0);

    always_comb begin
        w_code = r_shadow[4:0];
        case (r_idx)
            2'd3:    w_code = r_shadow[19:15];
            2'd2:    w_code = r_shadow[14:10];
            2'd1:    w_code = r_shadow[9:5];
            default: w_code = r_shadow[4:0];
        endcase
    end

    always_comb begin
        w_glyph = 7'h7F;
        case (w_code)
            5'h00: w_glyph = 7'h40;
            5'h01: w_glyph = 7'h79;
            5'h02: w_glyph = 7'h24;
            5'h03: w_glyph = 7'h30;
            5'h04: w_glyph = 7'h19;
            5'h05: w_glyph = 7'h12;
            5'h06: w_glyph = 7'h02;
            5'h07: w_glyph = 7'h78;
            5'h08: w_glyph = 7'h00;
            5'h09: w_glyph = 7'h10;
            5'h0A: w_glyph = 7'h08;
            5'h0B: w_glyph = 7'h03;
            5'h0C: w_glyph = 7'h46;
            5'h0D: w_glyph = 7'h21;
            5'h0E: w_glyph = 7'h06;
            5'h0F: w_glyph = 7'h0E;
            5'h10: w_glyph = 7'h46;
            5'h11: w_glyph = 7'h47;
            5'h12: w_glyph = 7'h0C;
            5'h13: w_glyph = 7'h06;
            5'h14: w_glyph = 7'h2B;
            5'h15: w_glyph = 7'h23;
            5'h16: w_glyph = 7'h3F;
            default: w_glyph = 7'h7F;
        endcase
    end

`ifdef SSD_BLINK_EN
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;
    logic [3:0]    r_mask_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_mask_sh   <= 4'b0000;
        end else begin
            if (r_blink_cnt == BW'(BLINK_TICKS - 1)) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
            if (w_frame_end) r_mask_sh <= blink_mask;
        end
    end

    assign w_blank = r_phase & r_mask_sh[r_idx];
`else
    logic w_unused_mask;
    assign w_unused_mask = ^blink_mask;
    assign w_blank       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick        <= '0;
            r_idx         <= 2'd3;
            r_shadow      <= '1;
            r_loaded      <= 1'b0;
            r_an          <= 4'b1111;
            r_seg         <= 7'h7F;
            r_frame_start <= 1'b0;
        end else begin
            r_tick <= w_wrap ? '0 : r_tick + 1'b1;
            if (w_wrap) r_idx <= r_idx - 2'd1;
            if (w_frame_end) r_shadow <= sym;
            // Pulse lands one cycle after the load has become visible in r_shadow.
            r_loaded      <= w_frame_end;
            r_frame_start <= r_loaded;
            // First tick of each digit slot is blanked to avoid ghosting between digits.
            r_an  <= (r_tick == '0) ? 4'b1111 : ~(4'b0001 << r_idx);
            r_seg <= w_blank ? 7'h7F : w_glyph;
        end
    end

    assign seg         = r_seg;
    assign an          = r_an;
    assign dp          = 1'b1;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver with DIGIT_TICKS=4, BLINK_TICKS=16; arithmetic reference model of the scan.
module tb_ssd_scan_driver;

    localparam int DT = 4;
    localparam int BT = 16;
    localparam int FRAME = 4 * DT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] sym = '0;
    logic [3:0]  blink_mask = '0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        frame_start;

    int checks = 0;
    int failures = 0;

    ssd_scan_driver #(.DIGIT_TICKS(DT), .BLINK_TICKS(BT)) dut (
        .clk(clk), .rst(rst), .sym(sym), .blink_mask(blink_mask),
        .seg(seg), .an(an), .dp(dp), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [4:0] c);
        case (c)
            5'h00: return 7'h40; 5'h01: return 7'h79; 5'h02: return 7'h24; 5'h03: return 7'h30;
            5'h04: return 7'h19; 5'h05: return 7'h12; 5'h06: return 7'h02; 5'h07: return 7'h78;
            5'h08: return 7'h00; 5'h09: return 7'h10; 5'h0A: return 7'h08; 5'h0B: return 7'h03;
            5'h0C: return 7'h46; 5'h0D: return 7'h21; 5'h0E: return 7'h06; 5'h0F: return 7'h0E;
            5'h10: return 7'h46; 5'h11: return 7'h47; 5'h12: return 7'h0C; 5'h13: return 7'h06;
            5'h14: return 7'h2B; 5'h15: return 7'h23; 5'h16: return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    // Reference: n = clock edges since reset; everything follows from n by division/modulo.
    int          n = 0;
    int          m_tick, m_idx;
    logic [19:0] m_sh = '1;
    logic [3:0]  m_mask = '0;
    logic [6:0]  exp_seg = 7'h7F;
    logic [3:0]  exp_an = 4'hF;
    logic        exp_fs = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            n = 0; m_sh = '1; m_mask = '0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_fs = 1'b0;
        end else begin
            m_tick  = n % DT;
            m_idx   = 3 - ((n / DT) % 4);
            exp_an  = (m_tick == 0) ? 4'hF : ~(4'b0001 << m_idx);
            exp_seg = glyph(m_sh[5*m_idx +: 5]);
`ifdef SSD_BLINK_EN
            if (((n / BT) % 2 == 1) && m_mask[m_idx]) exp_seg = 7'h7F;
`endif
            exp_fs = (n >= 1) && (((n - 1) % FRAME) == FRAME - 1);
            if ((n % FRAME) == FRAME - 1) begin
                m_sh = sym; m_mask = blink_mask;
            end
            n++;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks += 4;
            if (an !== 4'b1111) begin failures++; $display("FAIL reset_an got=%b want=1111", an); end
            if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h want=7f", seg); end
            if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b want=1", dp); end
            if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs got=%b want=0", frame_start); end
        end
    endtask

    task automatic test_first_frame();
        sym = {5'h10, 5'h11, 5'h05, 5'h0D};
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            checks++;
            if (an !== exp_an || seg !== exp_seg || frame_start !== exp_fs) begin
                failures++;
                $display("FAIL first_frame_model k=%0d got an=%b seg=%h fs=%b want an=%b seg=%h fs=%b",
                         k, an, seg, frame_start, exp_an, exp_seg, exp_fs);
            end
            if (k == 16 || k == 17) begin
                checks++;
                if (frame_start !== (k == 17)) begin
                    failures++; $display("FAIL frame_start_cycle k=%0d got=%b", k, frame_start);
                end
            end
            if (k >= 18 && k <= 32 && (k - 18) % 4 != 3) begin
                logic [3:0] wa;
                logic [6:0] ws;
                case ((k - 18) / 4)
                    0: begin wa = 4'b0111; ws = 7'h46; end
                    1: begin wa = 4'b1011; ws = 7'h47; end
                    2: begin wa = 4'b1101; ws = 7'h12; end
                    default: begin wa = 4'b1110; ws = 7'h21; end
                endcase
                checks++;
                if (an !== wa || seg !== ws) begin
                    failures++;
                    $display("FAIL first_frame_digit k=%0d got an=%b seg=%h want an=%b seg=%h", k, an, seg, wa, ws);
                end
            end
        end
    endtask

    task automatic test_no_tearing();
        sym = {4{5'h16}};
        for (int k = 41; k <= 64; k++) begin
            @(negedge clk);
            checks++;
            if (an !== exp_an || seg !== exp_seg || frame_start !== exp_fs) begin
                failures++;
                $display("FAIL no_tearing_model k=%0d got an=%b seg=%h fs=%b want an=%b seg=%h fs=%b",
                         k, an, seg, frame_start, exp_an, exp_seg, exp_fs);
            end
            if (k == 42 || k == 50) begin
                checks++;
                if (seg !== ((k == 42) ? 7'h12 : 7'h3F)) begin
                    failures++; $display("FAIL no_tearing_seg k=%0d got=%h", k, seg);
                end
            end
        end
    endtask

    task automatic run_model(input string name, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            checks++;
            if (an !== exp_an || seg !== exp_seg || frame_start !== exp_fs || dp !== 1'b1) begin
                failures++;
                $display("FAIL %s k=%0d got an=%b seg=%h fs=%b dp=%b want an=%b seg=%h fs=%b dp=1",
                         name, k, an, seg, frame_start, dp, exp_an, exp_seg, exp_fs);
            end
        end
    endtask

    task automatic test_undefined_code();
        sym = {5'h01, 5'h02, 5'h03, 5'h18};
        run_model("undefined_code", 40);
    endtask

    task automatic test_reset_mid();
        sym = {5'h0A, 5'h0B, 5'h0C, 5'h0E};
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (an !== 4'b1111 || seg !== 7'h7F || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got an=%b seg=%h fs=%b want an=1111 seg=7f fs=0", an, seg, frame_start);
        end
        rst = 1'b0;
        run_model("reset_mid_restart", 40);
    endtask

    task automatic test_blink();
        sym = '0;
        blink_mask = 4'b0001;
        run_model("blink", 100);
        blink_mask = 4'b0000;
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            checks++;
            if (an !== exp_an || seg !== exp_seg || frame_start !== exp_fs) begin
                failures++;
                $display("FAIL random k=%0d got an=%b seg=%h fs=%b want an=%b seg=%h fs=%b",
                         k, an, seg, frame_start, exp_an, exp_seg, exp_fs);
            end
            if ($urandom_range(0, 9) == 0) sym = 20'($urandom);
            if ($urandom_range(0, 19) == 0) blink_mask = 4'($urandom);
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_no_tearing();
        test_undefined_code();
        test_reset_mid();
        test_blink();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
